// File: rtl/inst_encoder_pkg.sv
`default_nettype none
// ============================================================================
// inst_encoder_pkg : shared RV32I ALU/operand/opcode codes and encoder types
// Revision 1.0
// ============================================================================
package inst_encoder_pkg;

    localparam logic [5:0] ALU_LB   = 6'd0;
    localparam logic [5:0] ALU_LH   = 6'd1;
    localparam logic [5:0] ALU_LW   = 6'd2;
    localparam logic [5:0] ALU_LBU  = 6'd3;
    localparam logic [5:0] ALU_LHU  = 6'd4;
    localparam logic [5:0] ALU_SB   = 6'd5;
    localparam logic [5:0] ALU_SH   = 6'd6;
    localparam logic [5:0] ALU_SW   = 6'd7;
    localparam logic [5:0] ALU_ADD  = 6'd8;
    localparam logic [5:0] ALU_SUB  = 6'd9;
    localparam logic [5:0] ALU_XOR  = 6'd10;
    localparam logic [5:0] ALU_OR   = 6'd11;
    localparam logic [5:0] ALU_AND  = 6'd12;
    localparam logic [5:0] ALU_SLL  = 6'd13;
    localparam logic [5:0] ALU_SRL  = 6'd14;
    localparam logic [5:0] ALU_SRA  = 6'd15;
    localparam logic [5:0] ALU_SLT  = 6'd16;
    localparam logic [5:0] ALU_SLTU = 6'd17;
    localparam logic [5:0] ALU_BEQ  = 6'd18;
    localparam logic [5:0] ALU_BNE  = 6'd19;
    localparam logic [5:0] ALU_BLT  = 6'd20;
    localparam logic [5:0] ALU_BGE  = 6'd21;
    localparam logic [5:0] ALU_BLTU = 6'd22;
    localparam logic [5:0] ALU_BGEU = 6'd23;
    localparam logic [5:0] ALU_JAL  = 6'd24;
    localparam logic [5:0] ALU_JALR = 6'd25;
    localparam logic [5:0] ALU_LUI  = 6'd26;
    localparam logic [5:0] ALU_NOP  = 6'd63;

    localparam logic [1:0] OP_TYPE_NONE = 2'd0;
    localparam logic [1:0] OP_TYPE_REG  = 2'd1;
    localparam logic [1:0] OP_TYPE_IMM  = 2'd2;
    localparam logic [1:0] OP_TYPE_PC   = 2'd3;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD_SUB = 3'd0;
    localparam logic [2:0] F3_SLL     = 3'd1;
    localparam logic [2:0] F3_SLT     = 3'd2;
    localparam logic [2:0] F3_SLTU    = 3'd3;
    localparam logic [2:0] F3_XOR     = 3'd4;
    localparam logic [2:0] F3_SRL_SRA = 3'd5;
    localparam logic [2:0] F3_OR      = 3'd6;
    localparam logic [2:0] F3_AND     = 3'd7;
    localparam logic [2:0] F3_BEQ     = 3'd0;
    localparam logic [2:0] F3_BNE     = 3'd1;
    localparam logic [2:0] F3_BLT     = 3'd4;
    localparam logic [2:0] F3_BGE     = 3'd5;
    localparam logic [2:0] F3_BLTU    = 3'd6;
    localparam logic [2:0] F3_BGEU    = 3'd7;
    localparam logic [2:0] F3_LB      = 3'd0;
    localparam logic [2:0] F3_LH      = 3'd1;
    localparam logic [2:0] F3_LW      = 3'd2;
    localparam logic [2:0] F3_LBU     = 3'd4;
    localparam logic [2:0] F3_LHU     = 3'd5;
    localparam logic [2:0] F3_SB      = 3'd0;
    localparam logic [2:0] F3_SH      = 3'd1;
    localparam logic [2:0] F3_SW      = 3'd2;
    localparam logic [2:0] F3_JALR    = 3'd0;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef enum logic [2:0] {
        FMT_R  = 3'd0,
        FMT_I  = 3'd1,
        FMT_SH = 3'd2,
        FMT_S  = 3'd3,
        FMT_B  = 3'd4,
        FMT_U  = 3'd5,
        FMT_J  = 3'd6
    } fmt_e;

    // True when v[31:lo] is a pure sign extension (all zeros or all ones).
    function automatic logic sext_fits(input logic [31:0] v, input int unsigned lo);
        logic [31:0] s;
        s = $signed(v) >>> lo;
        return (s == '0) || (s == '1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/enc_fifo2.sv
`default_nettype none
// ============================================================================
// enc_fifo2 : 2-entry valid/ready skid buffer with registered push-ready
// Revision 1.0
// ============================================================================
module enc_fifo2 #(
    parameter int                 DATA_W     = 64,
    parameter logic [DATA_W-1:0]  RESET_DATA = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    output logic              push_ready_o,
    input  logic              pop_ready_i,
    output logic              pop_valid_o,
    output logic [DATA_W-1:0] pop_data_o
);

    logic [1:0]        count_q, count_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic              ready_q;
    logic              w_pop;

    assign w_pop = (count_q != 2'd0) && pop_ready_i;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({push_i, w_pop})
            2'b10: begin
                if (count_q == 2'd0) head_d = push_data_i;
                else                 tail_d = push_data_i;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_d = push_data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = push_data_i;
                end
            end
            default: ;
        endcase
    end

    // Ready is computed from the next occupancy so it never depends on pop_ready_i combinationally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            head_q  <= RESET_DATA;
            tail_q  <= RESET_DATA;
            ready_q <= 1'b0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            ready_q <= (count_d != 2'd2);
        end
    end

    assign push_ready_o = ready_q;
    assign pop_valid_o  = (count_q != 2'd0);
    assign pop_data_o   = head_q;

endmodule
`default_nettype wire

// File: rtl/inst_encoder.sv
`default_nettype none
// ============================================================================
// inst_encoder : streaming RV32I field-bundle to instruction-word encoder
// Revision 1.0
// ============================================================================
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  rs1_src,
    input  logic [4:0]  rs2_src,
    input  logic [4:0]  rd_src,
    input  logic [31:0] imm,
    input  logic [5:0]  alucode,
    input  logic [1:0]  aluop1_type,
    input  logic [1:0]  aluop2_type,
    input  logic        is_load,
    input  logic        is_store,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_addr,
    output logic        err,
    output logic [7:0]  err_cnt
);

    logic        w_known, w_arith, w_ld_code, w_st_code;
    logic        w_range_ok, w_flags_ok, w_legal, w_accept, w_push;
    logic [6:0]  w_opcode, w_f7;
    logic [2:0]  w_f3;
    fmt_e        w_fmt;
    logic [31:0] w_inst;
    logic [63:0] w_fifo_out;

    logic [31:0] addr_q;
    logic        err_q;
    logic [7:0]  err_cnt_q;

    always_comb begin
        w_known   = 1'b1;
        w_arith   = 1'b0;
        w_ld_code = 1'b0;
        w_st_code = 1'b0;
        w_opcode  = OP_OPIMM;
        w_f3      = 3'd0;
        w_f7      = F7_BASE;
        w_fmt     = FMT_I;
        case (alucode)
            ALU_LUI:  begin w_opcode = OP_LUI;  w_fmt = FMT_U; end
            ALU_JAL:  begin w_opcode = OP_JAL;  w_fmt = FMT_J; end
            ALU_JALR: begin w_opcode = OP_JALR; w_f3 = F3_JALR; end
            ALU_BEQ:  begin w_opcode = OP_BRANCH; w_fmt = FMT_B; w_f3 = F3_BEQ;  end
            ALU_BNE:  begin w_opcode = OP_BRANCH; w_fmt = FMT_B; w_f3 = F3_BNE;  end
            ALU_BLT:  begin w_opcode = OP_BRANCH; w_fmt = FMT_B; w_f3 = F3_BLT;  end
            ALU_BGE:  begin w_opcode = OP_BRANCH; w_fmt = FMT_B; w_f3 = F3_BGE;  end
            ALU_BLTU: begin w_opcode = OP_BRANCH; w_fmt = FMT_B; w_f3 = F3_BLTU; end
            ALU_BGEU: begin w_opcode = OP_BRANCH; w_fmt = FMT_B; w_f3 = F3_BGEU; end
            ALU_SB:   begin w_opcode = OP_STORE; w_fmt = FMT_S; w_f3 = F3_SB; w_st_code = 1'b1; end
            ALU_SH:   begin w_opcode = OP_STORE; w_fmt = FMT_S; w_f3 = F3_SH; w_st_code = 1'b1; end
            ALU_SW:   begin w_opcode = OP_STORE; w_fmt = FMT_S; w_f3 = F3_SW; w_st_code = 1'b1; end
            ALU_LB:   begin w_opcode = OP_LOAD; w_f3 = F3_LB;  w_ld_code = 1'b1; end
            ALU_LH:   begin w_opcode = OP_LOAD; w_f3 = F3_LH;  w_ld_code = 1'b1; end
            ALU_LW:   begin w_opcode = OP_LOAD; w_f3 = F3_LW;  w_ld_code = 1'b1; end
            ALU_LBU:  begin w_opcode = OP_LOAD; w_f3 = F3_LBU; w_ld_code = 1'b1; end
            ALU_LHU:  begin w_opcode = OP_LOAD; w_f3 = F3_LHU; w_ld_code = 1'b1; end
            ALU_ADD, ALU_SUB: begin w_arith = 1'b1; w_f3 = F3_ADD_SUB; end
            ALU_SLL:          begin w_arith = 1'b1; w_f3 = F3_SLL;     end
            ALU_SLT:          begin w_arith = 1'b1; w_f3 = F3_SLT;     end
            ALU_SLTU:         begin w_arith = 1'b1; w_f3 = F3_SLTU;    end
            ALU_XOR:          begin w_arith = 1'b1; w_f3 = F3_XOR;     end
            ALU_SRL, ALU_SRA: begin w_arith = 1'b1; w_f3 = F3_SRL_SRA; end
            ALU_OR:           begin w_arith = 1'b1; w_f3 = F3_OR;      end
            ALU_AND:          begin w_arith = 1'b1; w_f3 = F3_AND;     end
            default:          w_known = 1'b0;
        endcase

        // Operand types pick between AUIPC, register and immediate forms of the ALU group.
        if (w_arith) begin
            if (alucode == ALU_SUB || alucode == ALU_SRA) w_f7 = F7_ALT;
            if (alucode == ALU_ADD && aluop1_type == OP_TYPE_IMM && aluop2_type == OP_TYPE_PC) begin
                w_opcode = OP_AUIPC;
                w_fmt    = FMT_U;
            end else if (aluop2_type == OP_TYPE_REG) begin
                w_opcode = OP_OP;
                w_fmt    = FMT_R;
            end else if (aluop2_type == OP_TYPE_IMM && alucode != ALU_SUB) begin
                w_opcode = OP_OPIMM;
                w_fmt    = (w_f3 == F3_SLL || w_f3 == F3_SRL_SRA) ? FMT_SH : FMT_I;
            end else begin
                w_known = 1'b0;
            end
        end
    end

    always_comb begin
        w_range_ok = 1'b1;
        w_inst     = '0;
        case (w_fmt)
            FMT_R: begin
                w_inst = {w_f7, rs2_src, rs1_src, w_f3, rd_src, w_opcode};
            end
            FMT_I: begin
                w_range_ok = sext_fits(imm, 11);
                w_inst     = {imm[11:0], rs1_src, w_f3, rd_src, w_opcode};
            end
            FMT_SH: begin
                w_range_ok = (imm[31:5] == '0);
                w_inst     = {w_f7, imm[4:0], rs1_src, w_f3, rd_src, w_opcode};
            end
            FMT_S: begin
                w_range_ok = sext_fits(imm, 11);
                w_inst     = {imm[11:5], rs2_src, rs1_src, w_f3, imm[4:0], w_opcode};
            end
            FMT_B: begin
                w_range_ok = !imm[0] && sext_fits(imm, 12);
                w_inst     = {imm[12], imm[10:5], rs2_src, rs1_src, w_f3,
                              imm[4:1], imm[11], w_opcode};
            end
            FMT_U: begin
                w_range_ok = (imm[11:0] == '0);
                w_inst     = {imm[31:12], rd_src, w_opcode};
            end
            FMT_J: begin
                w_range_ok = !imm[0] && sext_fits(imm, 20);
                w_inst     = {imm[20], imm[10:1], imm[11], imm[19:12], rd_src, w_opcode};
            end
            default: w_range_ok = 1'b0;
        endcase
    end

    assign w_flags_ok = !(is_load && is_store) && (is_load == w_ld_code) && (is_store == w_st_code);
    assign w_legal    = w_known && w_range_ok && w_flags_ok;
    assign w_accept   = in_valid && in_ready;
    assign w_push     = w_accept && w_legal;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q    <= BASE_ADDR;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            if (w_push) addr_q <= addr_q + 32'd4;
            err_q <= w_accept && !w_legal;
            if (w_accept && !w_legal && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    enc_fifo2 #(
        .DATA_W     (64),
        .RESET_DATA ({BASE_ADDR, 32'h0000_0000})
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (w_push),
        .push_data_i  ({addr_q, w_inst}),
        .push_ready_o (in_ready),
        .pop_ready_i  (out_ready),
        .pop_valid_o  (out_valid),
        .pop_data_o   (w_fifo_out)
    );

    assign out_inst = w_fifo_out[31:0];
    assign out_addr = w_fifo_out[63:32];
    assign err      = err_q;
    assign err_cnt  = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_encoder.sv
`default_nettype none
// ============================================================================
// tb_inst_encoder : directed and round-trip bench for inst_encoder
// Revision 1.0
// ============================================================================
module tb_inst_encoder;
    import inst_encoder_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_1000;

    typedef struct packed {
        logic [5:0]  alu;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [1:0]  t1, t2;
        logic        ld, st;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [4:0]  rs1_src = '0, rs2_src = '0, rd_src = '0;
    logic [31:0] imm = '0;
    logic [5:0]  alucode = ALU_NOP;
    logic [1:0]  aluop1_type = '0, aluop2_type = '0;
    logic        is_load = 1'b0, is_store = 1'b0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] out_inst, out_addr;
    logic        err;
    logic [7:0]  err_cnt;

    int          n_checks = 0;
    int          n_errors = 0;
    logic        last_err;
    logic [31:0] got_inst[$], got_addr[$], exp_inst[$];

    always #5 clk = ~clk;

    inst_encoder #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .rs1_src(rs1_src), .rs2_src(rs2_src), .rd_src(rd_src), .imm(imm),
        .alucode(alucode), .aluop1_type(aluop1_type), .aluop2_type(aluop2_type),
        .is_load(is_load), .is_store(is_store), .out_valid(out_valid),
        .out_ready(out_ready), .out_inst(out_inst), .out_addr(out_addr),
        .err(err), .err_cnt(err_cnt)
    );

    always @(negedge clk) begin
        #2;
        if (rst_n && out_valid && out_ready) begin
            got_inst.push_back(out_inst);
            got_addr.push_back(out_addr);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bundle_t mk(input logic [5:0] alu, input logic [4:0] rd, input logic [4:0] rs1,
                                   input logic [4:0] rs2, input logic [31:0] im, input logic [1:0] t1,
                                   input logic [1:0] t2, input logic ld, input logic st);
        bundle_t b;
        b.alu = alu; b.rd = rd; b.rs1 = rs1; b.rs2 = rs2; b.imm = im;
        b.t1 = t1; b.t2 = t2; b.ld = ld; b.st = st;
        return b;
    endfunction

    task automatic apply(input bundle_t b);
        alucode = b.alu; rd_src = b.rd; rs1_src = b.rs1; rs2_src = b.rs2; imm = b.imm;
        aluop1_type = b.t1; aluop2_type = b.t2; is_load = b.ld; is_store = b.st;
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send(input bundle_t b);
        int   n;
        logic acc;
        n = 0;
        apply(b);
        in_valid = 1'b1;
        do begin
            acc = in_ready;
            @(negedge clk);
            n++;
        end while (!acc && n < 100);
        if (!acc) check("send_timeout", 32'd0, 32'd1);
        last_err = err;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        got_inst.delete(); got_addr.delete(); exp_inst.delete();
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_count"}, got_inst.size(), exp_inst.size());
        for (int i = 0; i < exp_inst.size(); i++) begin
            if (i < got_inst.size()) begin
                check({tag, "_inst"}, got_inst[i], exp_inst[i]);
                check({tag, "_addr"}, got_addr[i], BASE + 32'(4 * i));
            end
        end
    endtask

    function automatic logic [31:0] gen_word();
        logic [31:0] r;
        logic [2:0]  f3;
        logic        alt;
        r   = $urandom;
        alt = r[30];
        f3  = 3'd0;
        case ($urandom_range(7, 0))
            0: begin
                case ($urandom_range(5, 0))
                    0: f3 = 3'd0; 1: f3 = 3'd2; 2: f3 = 3'd3;
                    3: f3 = 3'd4; 4: f3 = 3'd6; default: f3 = 3'd7;
                endcase
                return {r[31:15], f3, r[11:7], 7'b0010011};
            end
            1: begin
                f3 = r[0] ? 3'd5 : 3'd1;
                return {1'b0, alt && (f3 == 3'd5), 5'b0, r[24:15], f3, r[11:7], 7'b0010011};
            end
            2: begin
                f3 = r[14:12];
                return {1'b0, alt && (f3 == 3'd0 || f3 == 3'd5), 5'b0, r[24:15], f3, r[11:7], 7'b0110011};
            end
            3: begin
                case ($urandom_range(4, 0))
                    0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
                endcase
                return {r[31:15], f3, r[11:7], 7'b0000011};
            end
            4: begin
                f3 = 3'($urandom_range(2, 0));
                return {r[31:15], f3, r[11:7], 7'b0100011};
            end
            5: begin
                case ($urandom_range(5, 0))
                    0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd4;
                    3: f3 = 3'd5; 4: f3 = 3'd6; default: f3 = 3'd7;
                endcase
                return {r[31:15], f3, r[11:7], 7'b1100011};
            end
            6: return {r[31:7], alt ? 7'b0010111 : 7'b0110111};
            default: return alt ? {r[31:7], 7'b1101111} : {r[31:15], 3'b000, r[11:7], 7'b1100111};
        endcase
    endfunction

    // Independent RV32I decoder producing the bundle the encoder consumes.
    function automatic bundle_t decode(input logic [31:0] w);
        bundle_t b;
        b     = '0;
        b.rd  = w[11:7];
        b.rs1 = w[19:15];
        b.rs2 = w[24:20];
        b.t1  = OP_TYPE_REG;
        b.t2  = OP_TYPE_IMM;
        b.imm = {{20{w[31]}}, w[31:20]};
        b.alu = ALU_NOP;
        case (w[6:0])
            7'b0110111: begin b.alu = ALU_LUI; b.t1 = OP_TYPE_NONE; b.imm = {w[31:12], 12'h000}; end
            7'b0010111: begin b.alu = ALU_ADD; b.t1 = OP_TYPE_IMM; b.t2 = OP_TYPE_PC; b.imm = {w[31:12], 12'h000}; end
            7'b1101111: begin
                b.alu = ALU_JAL; b.t1 = OP_TYPE_PC;
                b.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            end
            7'b1100111: b.alu = ALU_JALR;
            7'b1100011: begin
                b.t2  = OP_TYPE_REG;
                b.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
                case (w[14:12])
                    3'd0: b.alu = ALU_BEQ;  3'd1: b.alu = ALU_BNE;
                    3'd4: b.alu = ALU_BLT;  3'd5: b.alu = ALU_BGE;
                    3'd6: b.alu = ALU_BLTU; default: b.alu = ALU_BGEU;
                endcase
            end
            7'b0000011: begin
                b.ld = 1'b1;
                case (w[14:12])
                    3'd0: b.alu = ALU_LB; 3'd1: b.alu = ALU_LH; 3'd2: b.alu = ALU_LW;
                    3'd4: b.alu = ALU_LBU; default: b.alu = ALU_LHU;
                endcase
            end
            7'b0100011: begin
                b.st  = 1'b1;
                b.imm = {{20{w[31]}}, w[31:25], w[11:7]};
                case (w[14:12])
                    3'd0: b.alu = ALU_SB; 3'd1: b.alu = ALU_SH; default: b.alu = ALU_SW;
                endcase
            end
            7'b0010011, 7'b0110011: begin
                if (w[5]) b.t2 = OP_TYPE_REG;
                if (!w[5] && (w[14:12] == 3'd1 || w[14:12] == 3'd5)) b.imm = {27'd0, w[24:20]};
                case (w[14:12])
                    3'd0: b.alu = (w[5] && w[30]) ? ALU_SUB : ALU_ADD;
                    3'd1: b.alu = ALU_SLL;
                    3'd2: b.alu = ALU_SLT;
                    3'd3: b.alu = ALU_SLTU;
                    3'd4: b.alu = ALU_XOR;
                    3'd5: b.alu = w[30] ? ALU_SRA : ALU_SRL;
                    3'd6: b.alu = ALU_OR;
                    default: b.alu = ALU_AND;
                endcase
            end
            default: b.alu = ALU_NOP;
        endcase
        return b;
    endfunction

    bundle_t b_addi, b_sub, b_lui, b_jal, b_sw, b_nop;

    initial begin
        b_addi = mk(ALU_ADD, 5'd1, 5'd0, 5'd0, 32'd5, OP_TYPE_REG, OP_TYPE_IMM, 1'b0, 1'b0);
        b_sub  = mk(ALU_SUB, 5'd3, 5'd1, 5'd2, 32'd0, OP_TYPE_REG, OP_TYPE_REG, 1'b0, 1'b0);
        b_lui  = mk(ALU_LUI, 5'd5, 5'd0, 5'd0, 32'h1234_5000, OP_TYPE_NONE, OP_TYPE_IMM, 1'b0, 1'b0);
        b_jal  = mk(ALU_JAL, 5'd1, 5'd0, 5'd0, 32'd8, OP_TYPE_PC, OP_TYPE_IMM, 1'b0, 1'b0);
        b_sw   = mk(ALU_SW, 5'd0, 5'd1, 5'd2, 32'd4, OP_TYPE_REG, OP_TYPE_IMM, 1'b0, 1'b1);
        b_nop  = mk(ALU_NOP, 5'd0, 5'd0, 5'd0, 32'd0, OP_TYPE_NONE, OP_TYPE_NONE, 1'b0, 1'b0);

        // Reset state
        idle(2);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_inst", out_inst, 0);
        check("rst_out_addr", out_addr, BASE);
        check("rst_err", err, 0);
        check("rst_err_cnt", err_cnt, 0);
        rst_n = 1'b1;
        idle(1);
        check("ready_after_rst", in_ready, 1);

        // Single ADDI with one-cycle latency
        send(b_addi);
        check("addi_valid", out_valid, 1);
        check("addi_inst", out_inst, 32'h0050_0093);
        check("addi_addr", out_addr, BASE);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        check("addi_popped", out_valid, 0);

        // Back-to-back stream
        do_reset();
        out_ready = 1'b1;
        send(b_sub); send(b_lui); send(b_jal); send(b_sw);
        idle(3);
        exp_inst = '{32'h4020_81B3, 32'h1234_52B7, 32'h0080_00EF, 32'h0020_A223};
        compare_stream("stream");

        // Backpressure
        do_reset();
        out_ready = 1'b0;
        send(b_addi); send(b_sub);
        apply(b_lui);
        in_valid = 1'b1;
        check("bp_ready_low", in_ready, 0);
        check("bp_head_inst", out_inst, 32'h0050_0093);
        idle(2);
        check("bp_head_stable", out_inst, 32'h0050_0093);
        check("bp_head_addr", out_addr, BASE);
        check("bp_ready_still_low", in_ready, 0);
        out_ready = 1'b1;
        send(b_lui);
        idle(4);
        exp_inst = '{32'h0050_0093, 32'h4020_81B3, 32'h1234_52B7};
        compare_stream("bp");

        // Illegal bundles and saturation
        do_reset();
        out_ready = 1'b1;
        send(b_nop);
        check("ill_nop_err", last_err, 1);
        send(mk(ALU_ADD, 5'd1, 5'd0, 5'd0, 32'h800, OP_TYPE_REG, OP_TYPE_IMM, 1'b0, 1'b0));
        check("ill_imm_err", last_err, 1);
        send(mk(ALU_BEQ, 5'd0, 5'd1, 5'd2, 32'd3, OP_TYPE_REG, OP_TYPE_REG, 1'b0, 1'b0));
        check("ill_beq_err", last_err, 1);
        send(mk(ALU_SUB, 5'd1, 5'd1, 5'd0, 32'd1, OP_TYPE_REG, OP_TYPE_IMM, 1'b0, 1'b0));
        check("ill_subi_err", last_err, 1);
        idle(1);
        check("ill_err_pulse_end", err, 0);
        check("ill_err_cnt", err_cnt, 4);
        check("ill_no_output", got_inst.size(), 0);
        send(b_addi);
        check("legal_no_err", last_err, 0);
        idle(2);
        exp_inst = '{32'h0050_0093};
        compare_stream("after_ill");
        repeat (300) send(b_nop);
        idle(1);
        check("err_cnt_sat", err_cnt, 255);

        // Reset with two words buffered
        do_reset();
        out_ready = 1'b0;
        send(b_addi); send(b_sub);
        check("mid_two_buffered", out_valid, 1);
        rst_n = 1'b0;
        idle(1);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_addr", out_addr, BASE);
        check("mid_rst_ready", in_ready, 0);
        rst_n = 1'b1;
        idle(1);
        got_inst.delete(); got_addr.delete(); exp_inst.delete();
        out_ready = 1'b1;
        send(b_lui);
        idle(2);
        exp_inst = '{32'h1234_52B7};
        compare_stream("post_rst");

        // Decode -> encode round trip
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [31:0] w;
            w = gen_word();
            exp_inst.push_back(w);
            send(decode(w));
        end
        idle(3);
        compare_stream("roundtrip");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
